// File: rtl/leaf_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_arb_pkg
//  Brief    : Shared types, constants and helpers for the leaf pair arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package leaf_arb_pkg;

    localparam int PKT_W     = 49;
    localparam int VALID_BIT = PKT_W - 1;

    typedef logic [PKT_W-1:0] pkt_t;
    typedef logic             page_t;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_pkt_fifo
//  Brief    : Synchronous packet FIFO; full/empty decoded from wrap-bit pointers.
//  Revision : 1.0 - initial release
// ============================================================================
module leaf_pkt_fifo
    import leaf_arb_pkg::*;
#(
    parameter int WIDTH = PKT_W,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_pop;
    logic               w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;

    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);

    assign pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/leaf_pair_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_pair_arbiter
//  Brief    : Merges two page FIFOs onto one BFT leaf (round robin) and steers
//             leaf packets back to the addressed page.
//  Revision : 1.0 - initial release
// ============================================================================
module leaf_pair_arbiter
    import leaf_arb_pkg::*;
#(
    parameter int PKT_W      = leaf_arb_pkg::PKT_W,
    parameter int FIFO_DEPTH = 4,
    parameter int DEST_BIT   = 42,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PKT_W-1:0] din_leaf_bft2interface,
    output logic [PKT_W-1:0] dout_leaf_interface2bft,
    input  logic             bft_ready,
    input  logic [PKT_W-1:0] din_page_0,
    input  logic [PKT_W-1:0] din_page_1,
    output logic [PKT_W-1:0] dout_page_0,
    output logic [PKT_W-1:0] dout_page_1,
    output logic             resend_0,
    output logic             resend_1,
    output logic [CNT_W-1:0] drop_cnt_0,
    output logic [CNT_W-1:0] drop_cnt_1,
    output logic             grant_last
);

    localparam int          c_CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] c_cnt_max   = 32'((64'd1 << CNT_W) - 64'd1);

    logic [PKT_W-1:0] w_din   [2];
    logic [PKT_W-1:0] w_head  [2];
    logic [c_CW-1:0]  w_count [2];
    logic [1:0]       w_full;
    logic [1:0]       w_empty;
    logic [1:0]       w_pop;
    logic             w_pop_any;
    page_t            w_sel;

    logic [PKT_W-1:0] r_dout_leaf;
    logic [PKT_W-1:0] r_dout_page_0;
    logic [PKT_W-1:0] r_dout_page_1;
    page_t            r_grant_last;
    page_t            r_rr_prio;
    logic             w_unused_count;

    assign w_din[0] = din_page_0;
    assign w_din[1] = din_page_1;
    assign w_unused_count = ^{w_count[0], w_count[1]};

    // ------------------------------------------------------------------
    // Per-page ingress: FIFO, drop detection, resend pulse, drop counter
    // ------------------------------------------------------------------
    for (genvar n = 0; n < 2; n++) begin : g_page
        logic             w_req;
        logic             w_push;
        logic             w_drop;
        logic             r_resend;
        logic [CNT_W-1:0] r_drop_cnt;

        assign w_req  = w_din[n][PKT_W-1];
        assign w_push = w_req && (!w_full[n] || w_pop[n]);
        assign w_drop = w_req && !w_push;

        leaf_pkt_fifo #(
            .WIDTH (PKT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (w_push),
            .push_data (w_din[n]),
            .pop       (w_pop[n]),
            .pop_data  (w_head[n]),
            .full      (w_full[n]),
            .empty     (w_empty[n]),
            .count     (w_count[n])
        );

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_resend   <= 1'b0;
                r_drop_cnt <= '0;
            end else begin
                r_resend <= w_drop;
                if (w_drop) begin
                    r_drop_cnt <= CNT_W'(sat_inc(32'(r_drop_cnt), c_cnt_max));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pop selection; r_rr_prio is the page favoured on a tie
    // ------------------------------------------------------------------
    always_comb begin
        w_sel = r_rr_prio;
        if (!w_empty[0] && w_empty[1]) begin
            w_sel = 1'b0;
        end else if (w_empty[0] && !w_empty[1]) begin
            w_sel = 1'b1;
        end
        w_pop_any = bft_ready && !(&w_empty);
        w_pop[0]  = w_pop_any && (w_sel == 1'b0);
        w_pop[1]  = w_pop_any && (w_sel == 1'b1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout_leaf  <= '0;
            r_grant_last <= 1'b0;
            r_rr_prio    <= 1'b0;
        end else if (w_pop_any) begin
            r_dout_leaf  <= w_head[w_sel];
            r_grant_last <= w_sel;
            r_rr_prio    <= ~w_sel;
        end else begin
            r_dout_leaf  <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Downstream steering: unbuffered, one register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout_page_0 <= '0;
            r_dout_page_1 <= '0;
        end else begin
            r_dout_page_0 <= '0;
            r_dout_page_1 <= '0;
            if (din_leaf_bft2interface[PKT_W-1]) begin
                if (din_leaf_bft2interface[DEST_BIT]) begin
                    r_dout_page_1 <= din_leaf_bft2interface;
                end else begin
                    r_dout_page_0 <= din_leaf_bft2interface;
                end
            end
        end
    end

    assign dout_leaf_interface2bft = r_dout_leaf;
    assign dout_page_0             = r_dout_page_0;
    assign dout_page_1             = r_dout_page_1;
    assign grant_last              = r_grant_last;
    assign resend_0                = g_page[0].r_resend;
    assign resend_1                = g_page[1].r_resend;
    assign drop_cnt_0              = g_page[0].r_drop_cnt;
    assign drop_cnt_1              = g_page[1].r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_leaf_pair_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leaf_pair_arbiter
//  Brief    : Directed self-checking bench for leaf_pair_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_pair_arbiter;

    localparam logic [48:0] VLD = 49'h1_0000_0000_0000;

    logic        clk;
    logic        reset_n;
    logic [48:0] din_leaf_bft2interface;
    logic [48:0] dout_leaf_interface2bft;
    logic        bft_ready;
    logic [48:0] din_page_0;
    logic [48:0] din_page_1;
    logic [48:0] dout_page_0;
    logic [48:0] dout_page_1;
    logic        resend_0;
    logic        resend_1;
    logic [7:0]  drop_cnt_0;
    logic [7:0]  drop_cnt_1;
    logic        grant_last;

    int checks = 0;
    int errors = 0;

    leaf_pair_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .din_leaf_bft2interface  (din_leaf_bft2interface),
        .dout_leaf_interface2bft (dout_leaf_interface2bft),
        .bft_ready               (bft_ready),
        .din_page_0              (din_page_0),
        .din_page_1              (din_page_1),
        .dout_page_0             (dout_page_0),
        .dout_page_1             (dout_page_1),
        .resend_0                (resend_0),
        .resend_1                (resend_1),
        .drop_cnt_0              (drop_cnt_0),
        .drop_cnt_1              (drop_cnt_1),
        .grant_last              (grant_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_flags();
        chk("resend_0", 64'(resend_0), 64'd0);
        chk("resend_1", 64'(resend_1), 64'd0);
    endtask

    logic [48:0] exp_seq [10];
    logic [48:0] pkt;

    initial begin
        reset_n                = 1'b0;
        bft_ready              = 1'b0;
        din_leaf_bft2interface = '0;
        din_page_0             = '0;
        din_page_1             = '0;
        tick();
        tick();
        // ---------------- reset state
        chk("rst_dout_leaf", 64'(dout_leaf_interface2bft), 64'd0);
        chk("rst_dout_p0", 64'(dout_page_0), 64'd0);
        chk("rst_dout_p1", 64'(dout_page_1), 64'd0);
        chk("rst_drop0", 64'(drop_cnt_0), 64'd0);
        chk("rst_drop1", 64'(drop_cnt_1), 64'd0);
        chk("rst_grant", 64'(grant_last), 64'd0);
        chk_idle_flags();
        reset_n = 1'b1;
        tick();

        // ---------------- contention: 4 cycles from both pages
        bft_ready  = 1'b1;
        exp_seq[0] = '0;
        exp_seq[1] = VLD | 49'h100;
        exp_seq[2] = VLD | 49'h200;
        exp_seq[3] = VLD | 49'h101;
        exp_seq[4] = VLD | 49'h201;
        exp_seq[5] = VLD | 49'h102;
        exp_seq[6] = VLD | 49'h202;
        exp_seq[7] = VLD | 49'h103;
        exp_seq[8] = VLD | 49'h203;
        exp_seq[9] = '0;
        for (int j = 0; j < 10; j++) begin
            din_page_0 = (j < 4) ? (VLD | (49'h100 + 49'(j))) : '0;
            din_page_1 = (j < 4) ? (VLD | (49'h200 + 49'(j))) : '0;
            tick();
            chk("cont_dout", 64'(dout_leaf_interface2bft), 64'(exp_seq[j]));
            if (j >= 1 && j <= 8) begin
                chk("cont_grant", 64'(grant_last), 64'((j - 1) % 2));
            end
            chk_idle_flags();
        end
        chk("cont_drop0", 64'(drop_cnt_0), 64'd0);
        chk("cont_drop1", 64'(drop_cnt_1), 64'd0);

        // ---------------- single packet latency
        pkt        = 49'h1_0000_0000_00AB;
        din_page_0 = pkt;
        tick();
        din_page_0 = '0;
        chk("single_t1", 64'(dout_leaf_interface2bft), 64'd0);
        tick();
        chk("single_t2", 64'(dout_leaf_interface2bft), 64'(pkt));
        chk("single_grant", 64'(grant_last), 64'd0);
        tick();
        chk("single_t3", 64'(dout_leaf_interface2bft), 64'd0);

        // ---------------- overflow on page 1 with backpressure
        bft_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din_page_1 = VLD | (49'h300 + 49'(i));
            tick();
            chk("ovf_resend1", 64'(resend_1), (i >= 4) ? 64'd1 : 64'd0);
            chk("ovf_dout", 64'(dout_leaf_interface2bft), 64'd0);
        end
        din_page_1 = '0;
        tick();
        chk("ovf_resend1_end", 64'(resend_1), 64'd0);
        chk("ovf_drop1", 64'(drop_cnt_1), 64'd2);
        chk("ovf_drop0", 64'(drop_cnt_0), 64'd0);
        bft_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ovf_drain", 64'(dout_leaf_interface2bft), 64'(VLD | (49'h300 + 49'(k))));
            chk("ovf_grant", 64'(grant_last), 64'd1);
        end
        tick();
        chk("ovf_drain_end", 64'(dout_leaf_interface2bft), 64'd0);

        // ---------------- full FIFO with simultaneous push and pop
        bft_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din_page_0 = VLD | (49'h400 + 49'(i));
            tick();
        end
        chk("full_no_resend", 64'(resend_0), 64'd0);
        bft_ready  = 1'b1;
        din_page_0 = VLD | 49'h404;
        tick();
        chk("full_pop_dout", 64'(dout_leaf_interface2bft), 64'(VLD | 49'h400));
        chk("full_pop_resend", 64'(resend_0), 64'd0);
        bft_ready  = 1'b0;
        din_page_0 = VLD | 49'h405;
        tick();
        chk("full_still_resend", 64'(resend_0), 64'd1);
        chk("full_still_drop0", 64'(drop_cnt_0), 64'd1);
        chk("full_still_dout", 64'(dout_leaf_interface2bft), 64'd0);
        din_page_0 = '0;
        bft_ready  = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("full_drain", 64'(dout_leaf_interface2bft), 64'(VLD | (49'h400 + 49'(k))));
        end
        chk("full_resend_clr", 64'(resend_0), 64'd0);
        tick();
        chk("full_drain_end", 64'(dout_leaf_interface2bft), 64'd0);

        // ---------------- downstream steering
        din_leaf_bft2interface = 49'h1_0400_0000_0055;
        tick();
        chk("ds_p1", 64'(dout_page_1), 64'h1_0400_0000_0055);
        chk("ds_p1_other", 64'(dout_page_0), 64'd0);
        din_leaf_bft2interface = 49'h1_0000_0000_0066;
        tick();
        chk("ds_p0", 64'(dout_page_0), 64'h1_0000_0000_0066);
        chk("ds_p0_other", 64'(dout_page_1), 64'd0);
        din_leaf_bft2interface = 49'h0_0400_0000_0077;
        tick();
        chk("ds_inv_p0", 64'(dout_page_0), 64'd0);
        chk("ds_inv_p1", 64'(dout_page_1), 64'd0);

        // ---------------- mid-operation asynchronous reset
        bft_ready  = 1'b0;
        din_page_0 = VLD | 49'h500;
        din_page_1 = VLD | 49'h600;
        tick();
        din_page_0 = VLD | 49'h501;
        din_page_1 = VLD | 49'h601;
        din_leaf_bft2interface = 49'h1_0000_0000_0077;
        tick();
        chk("pre_rst_p0", 64'(dout_page_0), 64'h1_0000_0000_0077);
        din_page_0 = '0;
        din_page_1 = '0;
        din_leaf_bft2interface = '0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_dout_p0", 64'(dout_page_0), 64'd0);
        chk("mrst_drop0", 64'(drop_cnt_0), 64'd0);
        chk("mrst_drop1", 64'(drop_cnt_1), 64'd0);
        chk("mrst_grant", 64'(grant_last), 64'd0);
        chk("mrst_dout_leaf", 64'(dout_leaf_interface2bft), 64'd0);
        tick();
        tick();
        reset_n    = 1'b1;
        bft_ready  = 1'b1;
        din_page_0 = VLD | 49'h700;
        din_page_1 = VLD | 49'h800;
        tick();
        din_page_0 = '0;
        din_page_1 = '0;
        chk("post_rst_t1", 64'(dout_leaf_interface2bft), 64'd0);
        tick();
        chk("post_rst_first", 64'(dout_leaf_interface2bft), 64'(VLD | 49'h700));
        chk("post_rst_grant", 64'(grant_last), 64'd0);
        tick();
        chk("post_rst_second", 64'(dout_leaf_interface2bft), 64'(VLD | 49'h800));
        tick();
        chk("post_rst_flushed", 64'(dout_leaf_interface2bft), 64'd0);
        chk_idle_flags();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
